pong_buttons: RTL and testbench

PONG_BUTTONS -- requirements
Module: pong_buttons

---
 rtl/pong_pkg.sv | 24 ++
 rtl/pong_debounce.sv | 71 +++++++
 rtl/pong_buttons.sv | 79 +++++++
 tb/tb_pong_buttons.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared constants for the pong button front end: default debounce
//            length, debounce counter width and player channel indices.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

   // 10 ms of stable input at the 16 MHz board clock
   localparam int unsigned DEBOUNCE_DEFAULT = 160_000;
   // Smallest width whose range exceeds DEBOUNCE_DEFAULT
   localparam int unsigned DEBOUNCE_CNT_W   = 18;

   // Player channel indices into the 2-bit button/ack/status vectors
   localparam int LEFT        = 0;
   localparam int RIGHT       = 1;
   localparam int NUM_PLAYERS = 2;

endpackage : pong_pkg

`default_nettype wire

// File: rtl/pong_debounce.sv
// ============================================================================
// Module   : pong_debounce
// Purpose  : One button channel: 2-flop synchronizer on the inverted
//            (active-high) pin, then a counter that accepts a new level only
//            after it has been seen DEBOUNCE_CYCLES consecutive cycles.
// Ports    : clk    - system clock
//            rst    - synchronous active-high reset
//            btn_n  - raw asynchronous pin, active-low
//            level  - debounced level, 1 = pressed (registered)
//            rise   - 1 for the cycle whose edge will set level from 0 to 1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_debounce
   import pong_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             stable;
   logic [CNT_W-1:0] count;
   logic             differs;
   logic             accept;

   always_comb begin
      differs = sync_2 ^ stable;
      // The counter saturates at LAST, so this edge is the one that commits
      accept  = differs && (count == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         stable <= 1'b0;
         count  <= '0;
      end else begin
         sync_1 <= ~btn_n;
         sync_2 <= sync_1;
         if (!differs) begin
            // Any return to the stable level discards a partial count
            count <= '0;
         end else if (accept) begin
            stable <= sync_2;
            count  <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

   assign level = stable;
   // Built from registered state only, so the parent can act on the same
   // edge that level rises without an input-to-output path.
   assign rise  = accept & sync_2;

endmodule : pong_debounce

`default_nettype wire

// File: rtl/pong_buttons.sv
// ============================================================================
// Module   : pong_buttons
// Purpose  : Two-player button front end for the pong core. Debounces both
//            pins and turns each debounced press into a sticky hit request
//            that the core acknowledges; a press arriving while the previous
//            hit is still pending latches an overrun flag until reset.
// Ports    : _i_clk      - 16 MHz system clock
//            _i_rst      - synchronous active-high reset
//            _i_btn_n    - raw pins, active-low; [0]=left, [1]=right
//            _i_ack      - per-player hit acknowledge from the core
//            _o_pressed  - debounced level, 1 = pressed
//            _o_hit      - sticky hit request
//            _o_overrun  - sticky, press while hit still unacknowledged
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_buttons
   import pong_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
   input  logic                   _i_clk,
   input  logic                   _i_rst,
   input  logic [NUM_PLAYERS-1:0] _i_btn_n,
   input  logic [NUM_PLAYERS-1:0] _i_ack,
   output logic [NUM_PLAYERS-1:0] _o_pressed,
   output logic [NUM_PLAYERS-1:0] _o_hit,
   output logic [NUM_PLAYERS-1:0] _o_overrun
);

   logic [NUM_PLAYERS-1:0] level;
   logic [NUM_PLAYERS-1:0] rise;
   logic [NUM_PLAYERS-1:0] hit;
   logic [NUM_PLAYERS-1:0] overrun;

   pong_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_left (
      .clk   (_i_clk),
      .rst   (_i_rst),
      .btn_n (_i_btn_n[LEFT]),
      .level (level[LEFT]),
      .rise  (rise[LEFT])
   );

   pong_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_right (
      .clk   (_i_clk),
      .rst   (_i_rst),
      .btn_n (_i_btn_n[RIGHT]),
      .level (level[RIGHT]),
      .rise  (rise[RIGHT])
   );

   always_ff @(posedge _i_clk) begin
      if (_i_rst) begin
         hit     <= '0;
         overrun <= '0;
      end else begin
         // A new press wins over an acknowledge on the same edge
         hit     <= rise | (hit & ~_i_ack);
         // Only a press that lands on a still-pending, unacknowledged hit
         // counts as lost; acking on the same edge hands it over cleanly.
         overrun <= overrun | (rise & hit & ~_i_ack);
      end
   end

   assign _o_pressed = level;
   assign _o_hit     = hit;
   assign _o_overrun = overrun;

endmodule : pong_buttons

`default_nettype wire

// File: tb/tb_pong_buttons.sv
`default_nettype none

module tb_pong_buttons;

   localparam int unsigned DEB = 8;
   localparam int          LAT = DEB + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] btn_n = 2'b11;
   logic [1:0] ack = 2'b00;
   logic [1:0] pressed;
   logic [1:0] hit;
   logic [1:0] overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pong_buttons #(
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (18)
   ) dut (
      ._i_clk     (clk),
      ._i_rst     (rst),
      ._i_btn_n   (btn_n),
      ._i_ack     (ack),
      ._o_pressed (pressed),
      ._o_hit     (hit),
      ._o_overrun (overrun)
   );

   // Advance one rising edge and settle past it
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      btn_n = 2'b11; ack = 2'b00; rst = 1'b1;
      tick; tick;
      rst = 1'b0;
      total++; if (pressed !== 2'b00) begin bad++; $display("FAIL reset_pressed: got %b want 00", pressed); end
      total++; if (hit !== 2'b00) begin bad++; $display("FAIL reset_hit: got %b want 00", hit); end
      total++; if (overrun !== 2'b00) begin bad++; $display("FAIL reset_overrun: got %b want 00", overrun); end
   endtask

   task automatic test_press_left;
      logic [1:0] exp;
      btn_n[0] = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick;
         exp = (k >= LAT) ? 2'b01 : 2'b00;
         total++; if (pressed !== exp) begin bad++; $display("FAIL press_left_pressed edge %0d: got %b want %b", k, pressed, exp); end
         total++; if (hit !== exp) begin bad++; $display("FAIL press_left_hit edge %0d: got %b want %b", k, hit, exp); end
      end
      total++; if (overrun !== 2'b00) begin bad++; $display("FAIL press_left_overrun: got %b want 00", overrun); end
   endtask

   task automatic test_ack;
      for (int k = LAT + 1; k < 15; k++) begin
         tick;
         total++; if (hit !== 2'b01) begin bad++; $display("FAIL ack_hold_hit edge %0d: got %b want 01", k, hit); end
      end
      ack[0] = 1'b1;
      tick;
      ack = 2'b00;
      total++; if (hit !== 2'b00) begin bad++; $display("FAIL ack_clear_hit: got %b want 00", hit); end
      total++; if (pressed !== 2'b01) begin bad++; $display("FAIL ack_pressed: got %b want 01", pressed); end
      tick;
      total++; if (hit !== 2'b00) begin bad++; $display("FAIL ack_stay_clear: got %b want 00", hit); end
      ack = 2'b11;
      tick;
      ack = 2'b00;
      total++; if (hit !== 2'b00) begin bad++; $display("FAIL ack_idle_hit: got %b want 00", hit); end
      total++; if (overrun !== 2'b00) begin bad++; $display("FAIL ack_idle_overrun: got %b want 00", overrun); end
   endtask

   task automatic test_overrun;
      // release: symmetric latency, never sets hit
      btn_n[0] = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         tick;
         total++; if (pressed[0] !== (k < LAT)) begin bad++; $display("FAIL release_pressed edge %0d: got %b want %b", k, pressed[0], k < LAT); end
         total++; if (hit[0] !== 1'b0) begin bad++; $display("FAIL release_hit edge %0d: got %b want 0", k, hit[0]); end
      end
      // first press onto idle hit: no overrun
      btn_n[0] = 1'b0;
      for (int k = 1; k <= LAT; k++) tick;
      total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL ovr_first_hit: got %b want 1", hit[0]); end
      total++; if (overrun[0] !== 1'b0) begin bad++; $display("FAIL ovr_first_overrun: got %b want 0", overrun[0]); end
      // release without ack: hit must stay pending
      btn_n[0] = 1'b1;
      for (int k = 1; k <= LAT; k++) tick;
      total++; if (pressed[0] !== 1'b0) begin bad++; $display("FAIL ovr_release_pressed: got %b want 0", pressed[0]); end
      total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL ovr_release_hit: got %b want 1", hit[0]); end
      total++; if (overrun[0] !== 1'b0) begin bad++; $display("FAIL ovr_release_overrun: got %b want 0", overrun[0]); end
      // second press while hit pending: overrun on the rise edge
      btn_n[0] = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick;
         total++; if (overrun[0] !== (k >= LAT)) begin bad++; $display("FAIL ovr_second_overrun edge %0d: got %b want %b", k, overrun[0], k >= LAT); end
         total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL ovr_second_hit edge %0d: got %b want 1", k, hit[0]); end
      end
      total++; if (overrun[1] !== 1'b0) begin bad++; $display("FAIL ovr_right_clean: got %b want 0", overrun[1]); end
      // ack clears hit but not overrun
      ack[0] = 1'b1;
      tick;
      ack = 2'b00;
      tick;
      total++; if (hit[0] !== 1'b0) begin bad++; $display("FAIL ovr_ack_hit: got %b want 0", hit[0]); end
      total++; if (overrun[0] !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun[0]); end
      // only reset clears overrun
      btn_n = 2'b11; rst = 1'b1;
      tick;
      rst = 1'b0;
      total++; if ({pressed, hit, overrun} !== 6'b0) begin bad++; $display("FAIL ovr_reset_all: got %b want 000000", {pressed, hit, overrun}); end
      tick; tick;
   endtask

   task automatic test_glitch_right;
      int glen [3] = '{5, 5, 7};
      for (int g = 0; g < 3; g++) begin
         btn_n[1] = 1'b0;
         for (int k = 0; k < glen[g]; k++) begin
            tick;
            total++; if ({pressed, hit} !== 4'b0) begin bad++; $display("FAIL glitch%0d_low cycle %0d: got %b want 0000", g, k, {pressed, hit}); end
         end
         btn_n[1] = 1'b1;
         for (int k = 0; k < 6; k++) begin
            tick;
            total++; if ({pressed, hit} !== 4'b0) begin bad++; $display("FAIL glitch%0d_gap cycle %0d: got %b want 0000", g, k, {pressed, hit}); end
         end
      end
   endtask

   task automatic test_ack_on_rise;
      btn_n[0] = 1'b0;
      for (int k = 1; k <= LAT; k++) tick;
      btn_n[0] = 1'b1;
      for (int k = 1; k <= LAT; k++) tick;
      total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL aor_pending_hit: got %b want 1", hit[0]); end
      btn_n[0] = 1'b0;
      for (int k = 1; k < LAT; k++) tick;
      ack[0] = 1'b1;
      tick;
      ack = 2'b00;
      total++; if (pressed[0] !== 1'b1) begin bad++; $display("FAIL aor_pressed: got %b want 1", pressed[0]); end
      total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL aor_hit_set_wins: got %b want 1", hit[0]); end
      total++; if (overrun[0] !== 1'b0) begin bad++; $display("FAIL aor_overrun: got %b want 0", overrun[0]); end
   endtask

   task automatic test_simultaneous;
      btn_n = 2'b11; rst = 1'b1;
      tick;
      rst = 1'b0;
      tick; tick;
      btn_n = 2'b00;
      for (int k = 1; k < LAT; k++) tick;
      total++; if (hit !== 2'b00) begin bad++; $display("FAIL sim_early_hit: got %b want 00", hit); end
      tick;
      total++; if (hit !== 2'b11) begin bad++; $display("FAIL sim_hit: got %b want 11", hit); end
      total++; if (pressed !== 2'b11) begin bad++; $display("FAIL sim_pressed: got %b want 11", pressed); end
      btn_n = 2'b11;
      for (int k = 1; k < LAT; k++) tick;
      total++; if (pressed !== 2'b11) begin bad++; $display("FAIL sim_release_early: got %b want 11", pressed); end
      tick;
      total++; if (pressed !== 2'b00) begin bad++; $display("FAIL sim_release: got %b want 00", pressed); end
      total++; if (hit !== 2'b11) begin bad++; $display("FAIL sim_release_hit: got %b want 11", hit); end
      total++; if (overrun !== 2'b00) begin bad++; $display("FAIL sim_overrun: got %b want 00", overrun); end
   endtask

   task automatic test_reset_mid;
      logic [1:0] exp;
      btn_n = 2'b11; rst = 1'b1;
      tick;
      rst = 1'b0;
      tick; tick;
      btn_n[0] = 1'b0;
      // two sync edges, then five counting edges
      for (int k = 0; k < 7; k++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      total++; if ({pressed, hit, overrun} !== 6'b0) begin bad++; $display("FAIL mid_reset_all: got %b want 000000", {pressed, hit, overrun}); end
      for (int k = 1; k <= LAT; k++) begin
         tick;
         exp = (k >= LAT) ? 2'b01 : 2'b00;
         total++; if (pressed !== exp) begin bad++; $display("FAIL mid_pressed edge %0d: got %b want %b", k, pressed, exp); end
         total++; if (hit !== exp) begin bad++; $display("FAIL mid_hit edge %0d: got %b want %b", k, hit, exp); end
      end
   endtask

   initial begin
      test_reset;
      test_press_left;
      test_ack;
      test_overrun;
      test_glitch_right;
      test_ack_on_rise;
      test_simultaneous;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pong_buttons

`default_nettype wire
